cmd_frame_parser: RTL and testbench

Parametrised successor to the timetag host-command parser. Accepts a byte stream from the FX2 command FIFO, frames it as SYNC/CMD/LEN/payload/optional checksum, and presents one complete command to the register/control logic through a ready/ack handshake. Adds configurable maximum payload, checksum checking, inter-byte timeout, error reporting and input back-pressure. One instance sits between the FX2 command FIFO and the timetag register file.

---
 rtl/cmd_pkg.sv | 28 ++
 rtl/cmd_timeout_counter.sv | 39 +++
 rtl/cmd_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the host command frame parser: FSM states,
// error codes and the default frame start marker.
package cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_HOLD
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE    = 2'd0;
  localparam err_t ERR_LEN     = 2'd1;
  localparam err_t ERR_CSUM    = 2'd2;
  localparam err_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

  // Error counter stops at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout: counts enabled idle cycles since the last clear and
// pulses 'expired' on the cycle the count would reach TIMEOUT_CYCLES.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] count_reg;
      logic          terminal;

      // A clear on the terminal cycle wins: the byte arrived in time.
      assign terminal = enable && !clear && (count_reg == CW'(TIMEOUT_CYCLES - 1));
      assign expired  = terminal;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (clear || !enable || terminal) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cmd_frame_parser.sv
// Frames the FX2 command byte stream as SYNC/CMD/LEN/payload/[XOR checksum]
// and holds one complete command for the register file until acknowledged.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter bit         CHECKSUM_EN    = 1'b1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     cmd_rdy,
  input  logic                     cmd_ack,
  output logic [7:0]               cmd_code,
  output logic [5:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     err_pulse,
  output logic [1:0]               err_code,
  output logic [7:0]               err_count
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t                   state_reg, state_next;
  logic [7:0]               code_reg, code_next;
  logic [5:0]               len_reg, len_next;
  logic [8*MAX_PAYLOAD-1:0] payload_reg, payload_next;
  logic [5:0]               idx_reg, idx_next;
  logic [7:0]               xor_reg, xor_next;
  logic                     err_pulse_reg, err_pulse_next;
  err_t                     err_code_reg, err_code_next;
  logic [7:0]               err_count_reg, err_count_next;

  logic                     accept;
  logic                     timer_en;
  logic                     timer_expired;
  logic                     err_raise;
  err_t                     err_sel;
  logic [MAX_PAYLOAD-1:0]   byte_we;

  assign accept   = in_valid && in_ready;
  assign timer_en = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                    (state_reg == ST_PAYLOAD) || (state_reg == ST_CSUM);

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear  (accept),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // One write strobe per payload slot, selected by the running byte index.
  generate
    for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_byte_we
      assign byte_we[gi] = (state_reg == ST_PAYLOAD) && accept && (idx_reg == 6'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    code_next      = code_reg;
    len_next       = len_reg;
    payload_next   = payload_reg;
    idx_next       = idx_reg;
    xor_next       = xor_reg;
    err_pulse_next = 1'b0;
    err_code_next  = err_code_reg;
    err_count_next = err_count_reg;
    err_raise      = 1'b0;
    err_sel        = ERR_NONE;

    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (byte_we[i]) payload_next[i*8 +: 8] = in_data;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_next   = ST_CMD;
          payload_next = '0;
        end
      end
      ST_CMD: begin
        if (accept) begin
          code_next  = in_data;
          xor_next   = in_data;
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if ((in_data == 8'd0) || (in_data > MAX_LEN)) begin
            err_raise  = 1'b1;
            err_sel    = ERR_LEN;
            state_next = ST_IDLE;
          end else begin
            len_next   = in_data[5:0];
            xor_next   = xor_reg ^ in_data;
            idx_next   = '0;
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          xor_next = xor_reg ^ in_data;
          idx_next = idx_reg + 6'd1;
          if ((idx_reg + 6'd1) == len_reg) begin
            state_next = CHECKSUM_EN ? ST_CSUM : ST_HOLD;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == xor_reg) begin
            state_next = ST_HOLD;
          end else begin
            err_raise  = 1'b1;
            err_sel    = ERR_CSUM;
            state_next = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (cmd_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Expiry only fires on cycles without an accepted byte.
    if (timer_expired) begin
      err_raise  = 1'b1;
      err_sel    = ERR_TIMEOUT;
      state_next = ST_IDLE;
    end

    if (err_raise) begin
      err_pulse_next = 1'b1;
      err_code_next  = err_sel;
      err_count_next = sat_inc8(err_count_reg);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      code_reg      <= '0;
      len_reg       <= '0;
      payload_reg   <= '0;
      idx_reg       <= '0;
      xor_reg       <= '0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      code_reg      <= code_next;
      len_reg       <= len_next;
      payload_reg   <= payload_next;
      idx_reg       <= idx_next;
      xor_reg       <= xor_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
      err_count_reg <= err_count_next;
    end
  end

  assign in_ready    = (state_reg != ST_HOLD);
  assign cmd_rdy     = (state_reg == ST_HOLD);
  assign cmd_code    = code_reg;
  assign cmd_len     = len_reg;
  assign cmd_payload = payload_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench: stimulus pushes expected frame/error events computed from
// the framing rules; a monitor pops and compares as the parser presents them.
module tb_cmd_frame_parser;
  import cmd_pkg::*;

  localparam logic [7:0] SYNC = 8'hAA;
  localparam int         MAXP = 8;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_valid_nc;
  logic [7:0]  in_data, in_data_nc;
  logic        in_ready, in_ready_nc;
  logic        cmd_rdy, cmd_rdy_nc;
  logic        cmd_ack, cmd_ack_nc;
  logic [7:0]  cmd_code, cmd_code_nc;
  logic [5:0]  cmd_len, cmd_len_nc;
  logic [63:0] cmd_payload, cmd_payload_nc;
  logic        err_pulse, err_pulse_nc;
  logic [1:0]  err_code, err_code_nc;
  logic [7:0]  err_count, err_count_nc;

  cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(SYNC), .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .cmd_payload(cmd_payload), .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count));

  cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(SYNC), .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(1024)) dut_nc (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_nc), .in_data(in_data_nc), .in_ready(in_ready_nc),
    .cmd_rdy(cmd_rdy_nc), .cmd_ack(cmd_ack_nc), .cmd_code(cmd_code_nc), .cmd_len(cmd_len_nc),
    .cmd_payload(cmd_payload_nc), .err_pulse(err_pulse_nc), .err_code(err_code_nc), .err_count(err_count_nc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  ecode;
    logic [7:0]  ecount;
    logic [7:0]  code;
    logic [5:0]  len;
    logic [63:0] payload;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   model_errs = 0;
  logic [1:0] model_last_err = ERR_NONE;
  longint cyc = 0;
  longint last_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: error counter saturates, err_code remembers the last error.
  task automatic expect_err(input logic [1:0] c);
    exp_t e;
    model_errs     = (model_errs < 255) ? model_errs + 1 : 255;
    model_last_err = c;
    e = '{is_err: 1'b1, ecode: c, ecount: 8'(model_errs), code: 8'h0, len: 6'h0, payload: 64'h0};
    exp_q.push_back(e);
  endtask

  task automatic expect_cmd(input logic [7:0] code, input logic [5:0] len, input logic [63:0] pay);
    exp_t e;
    e = '{is_err: 1'b0, ecode: model_last_err, ecount: 8'(model_errs), code: code, len: len, payload: pay};
    exp_q.push_back(e);
  endtask

  task automatic plan_frame(input logic [7:0] code, input logic [7:0] len_byte, input logic [7:0] pl[$],
                            input logic [7:0] corrupt, input bit push, output logic [7:0] bq[$]);
    logic [7:0]  cs;
    logic [63:0] pay;
    bq = {};
    bq.push_back(SYNC);
    bq.push_back(code);
    bq.push_back(len_byte);
    if (len_byte == 8'd0 || len_byte > 8'(MAXP)) begin
      if (push) expect_err(ERR_LEN);
      return;
    end
    cs  = code ^ len_byte;
    pay = '0;
    for (int i = 0; i < int'(len_byte); i++) begin
      bq.push_back(pl[i]);
      cs ^= pl[i];
      pay[i*8 +: 8] = pl[i];
    end
    bq.push_back(cs ^ corrupt);
    if (push) begin
      if (corrupt != 8'd0) expect_err(ERR_CSUM);
      else expect_cmd(code, len_byte[5:0], pay);
    end
  endtask

  // Called and returns at a falling edge; 'gap' idle cycles precede the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        flag("in_ready_wait_expired");
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bq[$], input int first_gap);
    for (int i = 0; i < bq.size(); i++)
      send_byte(bq[i], (i == 0) ? first_gap : int'($urandom_range(0, 3)));
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 || cmd_rdy) begin
      @(negedge clk);
      w++;
      if (w > 500) begin
        flag("drain_wait_expired");
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset_n && in_valid && in_ready) last_acc = cyc;
  end

  // Monitor: compares whatever the parser presents against the queue head.
  bit prev_rdy = 1'b0;
  bit prev_pulse = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_rdy   = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (err_pulse) begin
        chk("err_pulse_width", 64'(prev_pulse), 64'(0));
        if (exp_q.size() == 0) flag("unexpected_error_event");
        else begin
          e = exp_q.pop_front();
          chk("event_is_error", 64'(1), 64'(e.is_err));
          chk("err_code", 64'(err_code), 64'(e.ecode));
          chk("err_count", 64'(err_count), 64'(e.ecount));
          if (e.is_err && e.ecode == ERR_TIMEOUT)
            chk("timeout_latency", 64'(cyc - last_acc), 64'(16));
        end
      end
      if (cmd_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) flag("unexpected_cmd_event");
        else begin
          e = exp_q.pop_front();
          hold_e = e;
          chk("event_is_cmd", 64'(0), 64'(e.is_err));
          chk("cmd_code", 64'(cmd_code), 64'(e.code));
          chk("cmd_len", 64'(cmd_len), 64'(e.len));
          chk("cmd_payload", cmd_payload, e.payload);
          chk("cmd_err_code_held", 64'(err_code), 64'(e.ecode));
          chk("cmd_err_count_held", 64'(err_count), 64'(e.ecount));
          // cmd_rdy is visible in the cycle that follows the accepting edge
          chk("cmd_rdy_latency", 64'(cyc - last_acc), 64'(0));
        end
      end else if (cmd_rdy) begin
        chk("hold_in_ready", 64'(in_ready), 64'(0));
        chk("hold_code_stable", 64'(cmd_code), 64'(hold_e.code));
        chk("hold_len_stable", 64'(cmd_len), 64'(hold_e.len));
        chk("hold_payload_stable", cmd_payload, hold_e.payload);
      end
      prev_rdy   = cmd_rdy;
      prev_pulse = err_pulse;
    end
  end

  // Consumer: acknowledges each held frame after a random delay.
  initial begin
    int d;
    cmd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_rdy) begin
        d = $urandom_range(0, 12);
        repeat (d) @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("ack_release_rdy", 64'(cmd_rdy), 64'(0));
        chk("ack_release_ready", 64'(in_ready), 64'(1));
        chk("ack_keeps_code", 64'(cmd_code), 64'(hold_e.code));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] pl[$];
    logic [7:0] nc_bytes[$];
    logic [7:0] code, len_b, g;
    int kind, pending_gap, cut;

    reset_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    in_valid_nc = 1'b0; in_data_nc = 8'h00; cmd_ack_nc = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'(0));
    chk("rst_cmd_code", 64'(cmd_code), 64'(0));
    chk("rst_cmd_len", 64'(cmd_len), 64'(0));
    chk("rst_payload", cmd_payload, 64'(0));
    chk("rst_err_pulse", 64'(err_pulse), 64'(0));
    chk("rst_err_code", 64'(err_code), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Checksum-less instance: same frame with the trailing byte omitted.
    nc_bytes = {8'hAA, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40};
    foreach (nc_bytes[i]) begin
      in_valid_nc = 1'b1;
      in_data_nc  = nc_bytes[i];
      @(negedge clk);
    end
    in_valid_nc = 1'b0;
    chk("nc_cmd_rdy", 64'(cmd_rdy_nc), 64'(1));
    chk("nc_in_ready", 64'(in_ready_nc), 64'(0));
    chk("nc_cmd_code", 64'(cmd_code_nc), 64'h05);
    chk("nc_cmd_len", 64'(cmd_len_nc), 64'd4);
    chk("nc_payload", cmd_payload_nc, 64'h0000_0000_4000_0000);
    chk("nc_err_count", 64'(err_count_nc), 64'(0));
    cmd_ack_nc = 1'b1;
    @(negedge clk);
    cmd_ack_nc = 1'b0;
    chk("nc_ack_rdy", 64'(cmd_rdy_nc), 64'(0));
    chk("nc_ack_ready", 64'(in_ready_nc), 64'(1));
    chk("nc_code_kept", 64'(cmd_code_nc), 64'h05);

    // Basic frame with checksum 41.
    pl = {8'h00, 8'h00, 8'h00, 8'h40};
    plan_frame(8'h05, 8'h04, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);

    // Leading junk is dropped silently.
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pl = {8'h01};
    plan_frame(8'h01, 8'h01, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);

    // Length 0 and length MAX+1, then a frame containing SYNC as data.
    plan_frame(8'h01, 8'h00, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);
    plan_frame(8'h01, 8'h09, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);
    pl = {8'hAA, 8'hBB, 8'hCC};
    plan_frame(8'h22, 8'h03, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);

    // Checksum FF instead of 01.
    pl = {8'h01};
    plan_frame(8'h01, 8'h01, pl, 8'hFE, 1'b1, bq);
    send_frame(bq, 0);

    // Stall after AA 01.
    expect_err(ERR_TIMEOUT);
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);

    // Byte arriving on the terminal cycle keeps the frame alive.
    pl = {8'h5A, 8'hC3};
    plan_frame(8'h01, 8'h02, pl, 8'h00, 1'b1, bq);
    send_byte(bq[0], 20);
    send_byte(bq[1], 0);
    send_byte(bq[2], 15);
    for (int i = 3; i < bq.size(); i++) send_byte(bq[i], 0);

    // One cycle later is too late; the straggler is dropped in IDLE.
    expect_err(ERR_TIMEOUT);
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 16);

    pending_gap = 0;
    for (int t = 0; t < 150; t++) begin
      kind  = $urandom_range(0, 9);
      code  = 8'($urandom);
      len_b = 8'($urandom_range(1, MAXP));
      pl = {};
      for (int i = 0; i < MAXP; i++) pl.push_back(8'($urandom));
      case (kind)
        0: begin
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h55;
            send_byte(g, (j == 0) ? pending_gap : int'($urandom_range(0, 3)));
          end
          pending_gap = $urandom_range(0, 3);
          plan_frame(code, len_b, pl, 8'h00, 1'b1, bq);
        end
        1: begin
          len_b = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAXP + 1, 255));
          plan_frame(code, len_b, pl, 8'h00, 1'b1, bq);
        end
        2: plan_frame(code, len_b, pl, 8'($urandom_range(1, 255)), 1'b1, bq);
        3: begin
          plan_frame(code, len_b, pl, 8'h00, 1'b0, bq);
          cut = $urandom_range(1, bq.size() - 1);
          while (bq.size() > cut) void'(bq.pop_back());
          expect_err(ERR_TIMEOUT);
        end
        default: plan_frame(code, len_b, pl, 8'h00, 1'b1, bq);
      endcase
      send_frame(bq, pending_gap);
      pending_gap = (kind == 3) ? 20 : int'($urandom_range(0, 3));
    end

    // Reset in the middle of a payload.
    wait_drain();
    repeat (20) @(negedge clk);
    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    plan_frame(8'h03, 8'h05, pl, 8'h00, 1'b0, bq);
    for (int i = 0; i < 5; i++) send_byte(bq[i], 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_cmd_rdy", 64'(cmd_rdy), 64'(0));
    chk("midrst_cmd_code", 64'(cmd_code), 64'(0));
    chk("midrst_cmd_len", 64'(cmd_len), 64'(0));
    chk("midrst_payload", cmd_payload, 64'(0));
    chk("midrst_err_pulse", 64'(err_pulse), 64'(0));
    chk("midrst_err_code", 64'(err_code), 64'(0));
    chk("midrst_err_count", 64'(err_count), 64'(0));
    model_errs     = 0;
    model_last_err = ERR_NONE;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Saturation of the error counter.
    for (int t = 0; t < 256; t++) begin
      plan_frame(8'($urandom), 8'd0, pl, 8'h00, 1'b1, bq);
      send_frame(bq, 0);
    end
    wait_drain();
    chk("err_count_saturated", 64'(err_count), 64'd255);

    pl = {8'h01, 8'h02};
    plan_frame(8'h7E, 8'h02, pl, 8'h00, 1'b1, bq);
    send_frame(bq, 0);
    wait_drain();
    repeat (10) @(negedge clk);
    chk("queue_empty_at_end", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
